// File: rtl/audio_core_axi_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : audio_core_axi_lite_slave
// Description : AXI4-Lite slave for the audio core control/status register
//               bank. Single-beat writes (byte strobes) and reads into
//               NUM_REGS 32-bit registers; out-of-range accesses get SLVERR.
//               Register contents and a per-register write strobe are
//               exported to the audio datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_core_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]              reg_out,
    output logic [NUM_REGS-1:0]                 reg_wr_pulse
);

    localparam int          c_IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    // Write-side holding buffers and response state
    logic                   r_aw_full;
    logic [c_IDX_W-1:0]     r_aw_idx;
    logic                   r_w_full;
    logic [31:0]            r_w_data;
    logic [3:0]             r_w_strb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;

    // Read response state
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [31:0]            r_rdata;

    // Register bank and commit strobe
    logic [32*NUM_REGS-1:0] r_regs;
    logic [NUM_REGS-1:0]    r_wr_pulse;

    logic                   w_awready;
    logic                   w_wready;
    logic                   w_arready;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic [c_IDX_W-1:0]     w_cm_idx;
    logic [31:0]            w_cm_idx32;
    logic [31:0]            w_cm_data;
    logic [3:0]             w_cm_strb;
    logic                   w_cm_in_range;
    logic [31:0]            w_rd_idx32;
    logic                   w_rd_in_range;
    logic [31:0]            w_rd_word;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic w_unused_inputs;
    assign w_unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                               S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies depend only on registered state (and are held low in reset).
    assign w_awready = !ARESET && !r_aw_full && !r_bvalid;
    assign w_wready  = !ARESET && !r_w_full  && !r_bvalid;
    assign w_arready = !ARESET && !r_rvalid;

    assign w_aw_hs = S_AXI_AWVALID && w_awready;
    assign w_w_hs  = S_AXI_WVALID  && w_wready;
    assign w_ar_hs = S_AXI_ARVALID && w_arready;

    // Commit as soon as both halves exist, whether buffered or arriving now.
    assign w_commit  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_cm_idx  = r_aw_full ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_cm_data = r_w_full  ? r_w_data : S_AXI_WDATA;
    assign w_cm_strb = r_w_full  ? r_w_strb : S_AXI_WSTRB;

    assign w_cm_idx32    = {{(32-c_IDX_W){1'b0}}, w_cm_idx};
    assign w_cm_in_range = w_cm_idx32 < NUM_REGS;

    assign w_rd_idx32    = {{(32-c_IDX_W){1'b0}}, S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]};
    assign w_rd_in_range = w_rd_idx32 < NUM_REGS;

    // Read mux: select the addressed register word (zero when out of range).
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx32 == i) begin
                w_rd_word = r_regs[i*32 +: 32];
            end
        end
    end

    // Register bank: byte-strobed update and one-cycle write pulse on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_regs     <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit && w_cm_in_range) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_cm_idx32 == i) begin
                        r_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (w_cm_strb[b]) begin
                                r_regs[i*32 + b*8 +: 8] <= w_cm_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Write channel: independent AW/W capture, commit, and B response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_cm_in_range ? c_OKAY : c_SLVERR;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: capture data on AR handshake, hold until R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_in_range ? c_OKAY : c_SLVERR;
            r_rdata  <= w_rd_in_range ? w_rd_word : 32'h0;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign reg_out       = r_regs;
    assign reg_wr_pulse  = r_wr_pulse;

endmodule
`default_nettype wire
